clk_switch_ctrl: RTL and testbench

CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

---
 rtl/clk_switch_pkg.sv | 20 ++
 rtl/clksw_down_counter.sv | 33 +++
 rtl/clk_switch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_switch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clock-switch controller.
// The optional quiesce timeout is enabled by defining CLKSW_TIMEOUT_EN.
package clk_switch_pkg;

    localparam int SETTLE_CYCLES_DEF  = 16;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_SWITCH  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RELEASE = 3'd4
    } clksw_state_e;

    function automatic logic quiesce_active(input clksw_state_e st);
        return (st == ST_DRAIN) || (st == ST_SWITCH) || (st == ST_SETTLE);
    endfunction

endpackage

// File: rtl/clksw_down_counter.sv
// Loadable down-counter that saturates at zero and exposes a zero flag.
module clksw_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/clk_switch_ctrl.sv
// Sequencer for a glitchless clock mux: quiesce, switch select, settle, release.
// Define CLKSW_TIMEOUT_EN to abort a request when the quiesce acknowledge never arrives.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int   SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int   TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic SEL_RESET      = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    output logic quiesce_req,
    input  logic quiesce_ack,
    output logic sel,
    output logic done,
    output logic err
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    clksw_state_e state_r, state_s;
    logic target_r, target_s;
    logic sel_r, sel_s;
    logic done_r, done_s;
    logic quiesce_r, ready_r;
    logic settle_load_s, settle_dec_s, settle_zero_s;
`ifdef CLKSW_TIMEOUT_EN
    localparam logic [15:0] WAIT_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic wait_load_s, wait_dec_s, wait_zero_s;
    logic err_s, err_r;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_s       = state_r;
        target_s      = target_r;
        sel_s         = sel_r;
        done_s        = 1'b0;
        settle_load_s = 1'b0;
        settle_dec_s  = 1'b0;
`ifdef CLKSW_TIMEOUT_EN
        wait_load_s   = 1'b0;
        wait_dec_s    = 1'b0;
        err_s         = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (req_valid && (req_sel == sel_r)) begin
                    done_s = 1'b1;
                end else if (req_valid) begin
                    target_s = req_sel;
                    state_s  = ST_DRAIN;
`ifdef CLKSW_TIMEOUT_EN
                    wait_load_s = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // The select moves on the edge entering SWITCH, so SWITCH already sees the new clock.
                if (quiesce_ack) begin
                    state_s = ST_SWITCH;
                    sel_s   = target_r;
`ifdef CLKSW_TIMEOUT_EN
                end else if (wait_zero_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    wait_dec_s = 1'b1;
                end
`else
                end else begin
                    state_s = ST_DRAIN;
                end
`endif
            end
            ST_SWITCH: begin
                state_s       = ST_SETTLE;
                settle_load_s = 1'b1;
            end
            ST_SETTLE: begin
                // Acknowledge is deliberately not watched here.
                if (settle_zero_s) begin
                    state_s = ST_RELEASE;
                    done_s  = 1'b1;
                end else begin
                    settle_dec_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces the select back immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            target_r  <= SEL_RESET;
            sel_r     <= SEL_RESET;
            done_r    <= 1'b0;
            quiesce_r <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            target_r  <= target_s;
            sel_r     <= sel_s;
            done_r    <= done_s;
            quiesce_r <= quiesce_active(state_s);
            ready_r   <= (state_s == ST_IDLE);
        end
    end

    clksw_down_counter #(.WIDTH(8)) u_settle_cnt (
        .clk      (clk),
        .rst_n    (resetn),
        .load     (settle_load_s),
        .load_val (SETTLE_LOAD),
        .dec      (settle_dec_s),
        .zero     (settle_zero_s)
    );

`ifdef CLKSW_TIMEOUT_EN
    clksw_down_counter #(.WIDTH(16)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (resetn),
        .load     (wait_load_s),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec_s),
        .zero     (wait_zero_s)
    );

    // Abort pulse register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign req_ready   = ready_r;
    assign quiesce_req = quiesce_r;
    assign sel         = sel_r;
    assign done        = done_r;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Directed self-checking bench for clk_switch_ctrl (SETTLE_CYCLES=16, TIMEOUT_CYCLES=8).
module tb_clk_switch_ctrl;

    localparam int S = 16;
    localparam int T = 8;

    logic clk = 1'b0;
    logic resetn, req_valid, req_sel, quiesce_ack;
    logic req_ready, quiesce_req, sel, done, err;
    int   checks = 0;
    int   failures = 0;

    clk_switch_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .SEL_RESET(1'b0)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .quiesce_req (quiesce_req),
        .quiesce_ack (quiesce_ack),
        .sel         (sel),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_sel = 1'b0; quiesce_ack = 1'b0;
        repeat (3) step();
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rst_sel got=%b exp=0", sel); end
        checks++; if (quiesce_req !== 1'b0) begin failures++; $display("FAIL rst_quiesce got=%b exp=0", quiesce_req); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
        resetn = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_same_sel();
        req_valid = 1'b1; req_sel = 1'b0;
        step();
        req_valid = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL same_done got=%b exp=1", done); end
        checks++; if (quiesce_req !== 1'b0) begin failures++; $display("FAIL same_quiesce got=%b exp=0", quiesce_req); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL same_sel got=%b exp=0", sel); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%b exp=1", req_ready); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL same_done_clr got=%b exp=0", done); end
    endtask

    // Full change sequence; w = DRAIN cycles with ack low. Optional ack drop mid-settle and request noise.
    task automatic run_switch(input logic target, input int w, input bit drop_ack, input bit noise);
        int   total;
        logic exp_sel, exp_q, exp_done, exp_rdy;
        total = w + 2 + S;
        req_valid = 1'b1; req_sel = target; quiesce_ack = 1'b0;
        step();
        req_valid = 1'b0;
        for (int n = 0; n <= total + 1; n++) begin
            exp_sel  = (n >= w + 1) ? target : ~target;
            exp_q    = (n < total);
            exp_done = (n == total);
            exp_rdy  = (n > total);
            checks++; if (sel !== exp_sel) begin failures++; $display("FAIL sw_sel n=%0d got=%b exp=%b", n, sel, exp_sel); end
            checks++; if (quiesce_req !== exp_q) begin failures++; $display("FAIL sw_quiesce n=%0d got=%b exp=%b", n, quiesce_req, exp_q); end
            checks++; if (done !== exp_done) begin failures++; $display("FAIL sw_done n=%0d got=%b exp=%b", n, done, exp_done); end
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL sw_ready n=%0d got=%b exp=%b", n, req_ready, exp_rdy); end
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL sw_err n=%0d got=%b exp=0", n, err); end
            if (n <= total) begin
                quiesce_ack = (n >= w) && !(drop_ack && (n >= w + 9));
                if (noise) begin
                    req_valid = 1'b1;
                    req_sel   = n[0];
                end
                step();
            end
        end
        if (noise) begin
            req_valid = 1'b1; req_sel = target;
            step();
            req_valid = 1'b0;
            checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", done); end
            checks++; if (sel !== target) begin failures++; $display("FAIL b2b_sel got=%b exp=%b", sel, target); end
            step();
        end
        quiesce_ack = 1'b0;
    endtask

    task automatic test_switch();
        run_switch(1'b1, 4, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_switch(1'b0, 2, 1'b0, 1'b1);
    endtask

    task automatic test_ack_drop();
        run_switch(1'b1, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_sel = 1'b1; quiesce_ack = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL rmid_pre_sel got=%b exp=1", sel); end
        resetn = 1'b0;
        #1;
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rmid_async_sel got=%b exp=0", sel); end
        checks++; if (quiesce_req !== 1'b0) begin failures++; $display("FAIL rmid_quiesce got=%b exp=0", quiesce_req); end
        for (int n = 0; n < 3; n++) begin
            step();
            checks++; if ((done !== 1'b0) || (err !== 1'b0)) begin failures++; $display("FAIL rmid_pulse n=%0d got=%b%b exp=00", n, done, err); end
        end
        quiesce_ack = 1'b0;
        resetn = 1'b1;
        step();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", req_ready); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rmid_sel got=%b exp=0", sel); end
    endtask

`ifdef CLKSW_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_err;
        req_valid = 1'b1; req_sel = 1'b0; quiesce_ack = 1'b0;
        step();
        req_valid = 1'b0;
        for (int n = 0; n <= T + 1; n++) begin
            exp_err = (n == T);
            checks++; if (err !== exp_err) begin failures++; $display("FAIL to_err n=%0d got=%b exp=%b", n, err, exp_err); end
            checks++; if (quiesce_req !== (n < T)) begin failures++; $display("FAIL to_quiesce n=%0d got=%b", n, quiesce_req); end
            checks++; if (req_ready !== (n >= T)) begin failures++; $display("FAIL to_ready n=%0d got=%b", n, req_ready); end
            checks++; if ((sel !== 1'b1) || (done !== 1'b0)) begin failures++; $display("FAIL to_sel_done n=%0d got=%b%b exp=10", n, sel, done); end
            step();
        end
    endtask
`else
    task automatic test_no_timeout();
        int total;
        total = 40 + 2 + S;
        req_valid = 1'b1; req_sel = 1'b0; quiesce_ack = 1'b0;
        step();
        req_valid = 1'b0;
        for (int n = 0; n <= total; n++) begin
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL nto_err n=%0d got=%b exp=0", n, err); end
            checks++; if (done !== (n == total)) begin failures++; $display("FAIL nto_done n=%0d got=%b", n, done); end
            checks++; if (sel !== ((n >= 41) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL nto_sel n=%0d got=%b", n, sel); end
            quiesce_ack = (n >= 40);
            step();
        end
        quiesce_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_same_sel();
        test_switch();
        test_back_to_back();
        test_reset_mid();
        test_ack_drop();
`ifdef CLKSW_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
